// File: rtl/pc_sequencer.sv
// Run-control and next-PC sequencer for the IF stage: start, single-step,
// HALT detection with a fixed pipeline drain, abort, and an enabled-cycle counter.
module pc_sequencer #(
    parameter int NB_PC        = 6,
    parameter int NB_CYCLES    = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic                 i_abort,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [NB_PC-1:0]     i_branch_target,
    input  logic                 i_jump,
    input  logic [NB_PC-1:0]     i_jump_target,
    input  logic                 i_halt_fetched,
    input  logic [NB_PC-1:0]     i_pc,
    output logic [NB_PC-1:0]     o_next_pc,
    output logic                 o_pc_write,
    output logic                 o_pipe_enable,
    output logic                 o_if_flush,
    output logic                 o_running,
    output logic                 o_done,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [NB_DRN-1:0]    drain_q, drain_d;
    logic [NB_CYCLES-1:0] count_q, count_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 active;
    logic                 redirect;
    logic                 halt_stop;

    always_comb begin
        active    = (state_q == S_RUN) || (state_q == S_STEP);
        redirect  = i_jump | i_branch_taken;
        // A HALT on a path being redirected away from is squashed.
        halt_stop = i_halt_fetched & ~redirect;

        o_next_pc = i_pc + NB_PC'(1);
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end

        o_pc_write    = active & (redirect | (~i_stall & ~i_halt_fetched));
        o_if_flush    = active & redirect;
        o_pipe_enable = active | (state_q == S_DRAIN);
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_RUN;
                    end else if (i_step) begin
                        state_d = S_STEP;
                    end
                end
                S_RUN, S_STEP: begin
                    if (halt_stop) begin
                        state_d = S_DRAIN;
                        drain_d = DRN_LOAD;
                    end else if (state_q == S_STEP) begin
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q - NB_DRN'(1);
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (state_q == S_IDLE && !i_abort && i_start) begin
            count_d = '0;
        end else if (o_pipe_enable && count_q != '1) begin
            count_d = count_q + NB_CYCLES'(1);
        end
        running_d = (state_d == S_RUN) || (state_d == S_STEP) ||
                    (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            count_q   <= count_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign o_running     = running_q;
    assign o_done        = done_q;
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized run-control
// traffic compared every cycle against a behavioural model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, step, abort, stall, br, jump, halt;
    logic [5:0] bt, jt;
    logic [5:0] pc_q = 6'd0;
    logic [5:0] pc_ovr = 6'd0;
    logic       pc_ovr_en = 1'b0;
    logic [5:0] i_pc_w;

    logic [5:0]  npc_a, npc_b;
    logic        pw_a, pw_b, pe_a, pe_b, fl_a, fl_b;
    logic        run_a, run_b, done_a, done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign i_pc_w = pc_ovr_en ? pc_ovr : pc_q;

    pc_sequencer #(.NB_PC(6), .NB_CYCLES(16), .DRAIN_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_step(step),
        .i_abort(abort), .i_stall(stall), .i_branch_taken(br),
        .i_branch_target(bt), .i_jump(jump), .i_jump_target(jt),
        .i_halt_fetched(halt), .i_pc(i_pc_w), .o_next_pc(npc_a),
        .o_pc_write(pw_a), .o_pipe_enable(pe_a), .o_if_flush(fl_a),
        .o_running(run_a), .o_done(done_a), .o_cycle_count(cnt_a)
    );

    pc_sequencer #(.NB_PC(6), .NB_CYCLES(4), .DRAIN_CYCLES(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_step(step),
        .i_abort(abort), .i_stall(stall), .i_branch_taken(br),
        .i_branch_target(bt), .i_jump(jump), .i_jump_target(jt),
        .i_halt_fetched(halt), .i_pc(i_pc_w), .o_next_pc(npc_b),
        .o_pc_write(pw_b), .o_pipe_enable(pe_b), .o_if_flush(fl_b),
        .o_running(run_b), .o_done(done_b), .o_cycle_count(cnt_b)
    );

    // Behavioural model: mode flags, remaining drain cycles, unbounded count.
    bit m_run, m_step, m_drain, m_done;
    int m_left, m_cnt;

    typedef struct {
        bit en;
        bit pipe;
        bit pw;
        bit fl;
        int npc;
    } exp_t;

    function automatic exp_t calc();
        exp_t e;
        bit red;
        red    = jump || br;
        e.en   = m_run || m_step;
        e.pipe = e.en || m_drain;
        e.pw   = e.en && (red || (!stall && !halt));
        e.fl   = e.en && red;
        e.npc  = jump ? int'(jt) : br ? int'(bt) : (int'(i_pc_w) + 1) % 64;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   cn;
        if (!rst_n) begin
            m_run <= 0; m_step <= 0; m_drain <= 0; m_done <= 0;
            m_left <= 0; m_cnt <= 0;
        end else begin
            e = calc();
            cn = m_cnt + (e.pipe ? 1 : 0);
            pc_q <= e.pw ? 6'(e.npc) : i_pc_w;
            m_cnt <= cn;
            if (abort) begin
                m_run <= 0; m_step <= 0; m_drain <= 0; m_done <= 0;
            end else if (!m_run && !m_step && !m_drain && !m_done) begin
                if (start) begin
                    m_run <= 1;
                    m_cnt <= 0;
                end else if (step) begin
                    m_step <= 1;
                end
            end else if (e.en) begin
                if (halt && !(jump || br)) begin
                    m_run <= 0; m_step <= 0; m_drain <= 1; m_left <= 3;
                end else if (m_step) begin
                    m_step <= 0;
                end
            end else if (m_drain) begin
                if (m_left == 0) begin
                    m_drain <= 0; m_done <= 1;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        exp_t e;
        int   s16, s4;
        #2;
        e   = calc();
        s16 = (m_cnt > 65535) ? 65535 : m_cnt;
        s4  = (m_cnt > 15) ? 15 : m_cnt;
        chk("pipe_enable", 32'(pe_a), 32'(e.pipe));
        chk("pc_write", 32'(pw_a), 32'(e.pw));
        chk("if_flush", 32'(fl_a), 32'(e.fl));
        chk("running", 32'(run_a), 32'(m_run || m_step || m_drain));
        chk("done", 32'(done_a), 32'(m_done));
        chk("cycle_count", 32'(cnt_a), 32'(s16));
        chk("cnt4", 32'(cnt_b), 32'(s4));
        chk("pipe_enable4", 32'(pe_b), 32'(e.pipe));
        chk("pc_write4", 32'(pw_b), 32'(e.pw));
        chk("if_flush4", 32'(fl_b), 32'(e.fl));
        chk("running4", 32'(run_b), 32'(m_run || m_step || m_drain));
        chk("done4", 32'(done_b), 32'(m_done));
        if (e.en) begin
            chk("next_pc", 32'(npc_a), 32'(e.npc));
            chk("next_pc4", 32'(npc_b), 32'(e.npc));
        end
    end

    task automatic nc();
        @(negedge clk);
        start = 0; step = 0; abort = 0; stall = 0;
        br = 0; jump = 0; halt = 0; bt = 0; jt = 0;
    endtask

    initial begin
        start = 0; step = 0; abort = 0; stall = 0;
        br = 0; jump = 0; halt = 0; bt = 0; jt = 0;
        repeat (3) nc();
        rst_n = 1;
        nc(); #3;
        chk("lit_rst_running", 32'(run_a), 0);
        chk("lit_rst_count", 32'(cnt_a), 0);

        // Sequential PC from 5, then wrap at 63.
        nc(); pc_ovr_en = 1; pc_ovr = 6'd5; start = 1; #3;
        chk("lit_idle_pw", 32'(pw_a), 0);
        nc(); pc_ovr_en = 0; #3;
        chk("lit_npc6", 32'(npc_a), 6);
        chk("lit_pw1", 32'(pw_a), 1);
        nc(); #3; chk("lit_npc7", 32'(npc_a), 7);
        nc(); #3; chk("lit_npc8", 32'(npc_a), 8);
        nc(); pc_ovr_en = 1; pc_ovr = 6'd63; #3;
        chk("lit_npc_wrap", 32'(npc_a), 0);

        // Redirect beats stall; jump beats branch.
        nc(); pc_ovr_en = 0; stall = 1; br = 1; bt = 6'd20; #3;
        chk("lit_br_pw", 32'(pw_a), 1);
        chk("lit_br_npc", 32'(npc_a), 20);
        chk("lit_br_flush", 32'(fl_a), 1);
        nc(); stall = 1; br = 1; bt = 6'd20; jump = 1; jt = 6'd9; #3;
        chk("lit_jmp_npc", 32'(npc_a), 9);

        // HALT then four drain cycles, then DONE ignoring start.
        nc(); halt = 1; #3;
        chk("lit_halt_pw", 32'(pw_a), 0);
        chk("lit_halt_pe", 32'(pe_a), 1);
        for (int k = 0; k < 4; k++) begin
            nc(); br = 1; bt = 6'd3; stall = 1; #3;
            chk("lit_drain_pe", 32'(pe_a), 1);
            chk("lit_drain_pw", 32'(pw_a), 0);
            chk("lit_drain_fl", 32'(fl_a), 0);
        end
        nc(); start = 1; #3;
        chk("lit_done", 32'(done_a), 1);
        chk("lit_done_pe", 32'(pe_a), 0);
        nc(); #3;
        chk("lit_done_hold", 32'(done_a), 1);
        chk("lit_done_run", 32'(run_a), 0);

        // Abort out of DONE.
        nc(); abort = 1;
        nc(); #3;
        chk("lit_abort_done", 32'(done_a), 0);
        chk("lit_abort_run", 32'(run_a), 0);

        // Asynchronous reset in the middle of a run.
        nc(); start = 1;
        nc(); nc();
        @(posedge clk); #3; rst_n = 0; #1;
        chk("lit_async_pw", 32'(pw_a), 0);
        chk("lit_async_run", 32'(run_a), 0);
        chk("lit_async_pe", 32'(pe_a), 0);
        nc(); nc(); rst_n = 1;
        nc(); #3;
        chk("lit_post_rst_run", 32'(run_a), 0);
        chk("lit_post_rst_cnt", 32'(cnt_a), 0);

        // Three single steps.
        for (int k = 0; k < 3; k++) begin
            nc(); step = 1; #3;
            chk("lit_step_idle_pe", 32'(pe_a), 0);
            nc(); #3;
            chk("lit_step_pe", 32'(pe_a), 1);
            chk("lit_step_run", 32'(run_a), 1);
            nc(); #3;
            chk("lit_step_back", 32'(run_a), 0);
        end
        chk("lit_step_cnt", 32'(cnt_a), 3);

        // Start wins over step; abort in DRAIN.
        nc(); start = 1; step = 1;
        nc(); #3; chk("lit_ss_run", 32'(run_a), 1);
        nc(); #3; chk("lit_ss_run2", 32'(pe_a), 1);
        nc(); halt = 1;
        nc(); abort = 1; #3;
        chk("lit_drain_abort_pe", 32'(pe_a), 1);
        nc(); #3;
        chk("lit_drain_abort_run", 32'(run_a), 0);
        chk("lit_drain_abort_done", 32'(done_a), 0);
        chk("lit_drain_abort_pe2", 32'(pe_a), 0);

        // Counter saturation on the 4-bit instance.
        nc(); start = 1;
        repeat (20) nc();
        nc(); #3;
        chk("lit_cnt20", 32'(cnt_a), 20);
        chk("lit_cnt4_sat", 32'(cnt_b), 15);
        nc(); abort = 1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            nc();
            rst_n     = ($urandom % 300) != 0;
            start     = ($urandom % 8) == 0;
            step      = ($urandom % 8) == 0;
            abort     = ($urandom % 30) == 0;
            stall     = ($urandom % 4) == 0;
            br        = ($urandom % 6) == 0;
            jump      = ($urandom % 8) == 0;
            halt      = ($urandom % 10) == 0;
            bt        = 6'($urandom);
            jt        = 6'($urandom);
            pc_ovr_en = ($urandom % 16) == 0;
            pc_ovr    = 6'($urandom);
        end
        nc(); rst_n = 1; pc_ovr_en = 0;
        nc(); #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
